// File: rtl/reg_array_arbiter_pkg.sv
// reg_array_arbiter_pkg: FSM state encoding and default widths shared by the arbiter files
package reg_array_arbiter_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } state_t;
  localparam int DEF_NREQ   = 4;
  localparam int DEF_ADDR_W = 2;
  localparam int DEF_DATA_W = 4;
endpackage

// File: rtl/reg_array_arbiter_rr_pick.sv
// rr_pick: combinational round-robin pick, first set req at or after ptr (wrapping)
//   req     in  NREQ  request levels
//   ptr     in  PW    highest-priority index
//   win     out NREQ  one-hot winner, zero when no request
//   any_req out 1     at least one request pending
module rr_pick
  import reg_array_arbiter_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic            any_req
);
  // Walk distances from ptr largest-first so the nearest set request is written last.
  always_comb begin
    win = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      for (int i = 0; i < NREQ; i++)
        if (req[i] && ((i - int'(ptr) + NREQ) % NREQ) == k) begin
          win = '0;
          win[i] = 1'b1;
        end
    any_req = |req;
  end
endmodule

// File: rtl/reg_array_arbiter.sv
// reg_array_arbiter: round-robin sequencer sharing one register array among NREQ requesters
//   clk, clr            clock, async active-high reset
//   req/wr/addr/wdata   per-requester request level, op (1=write), packed address and data
//   gnt/ack             one-hot grant (ACCESS+ACK) and one-cycle completion pulse (ACK)
//   rdata               read result, valid with ack on reads, held otherwise
//   wrt_enab/wadd/radd/d_in/d_out  array-side port (array writes on negedge)
module reg_array_arbiter
  import reg_array_arbiter_pkg::*;
#(
  parameter int NREQ   = DEF_NREQ,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          wr,
  input  logic [NREQ*ADDR_W-1:0]   addr,
  input  logic [NREQ*DATA_W-1:0]   wdata,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          ack,
  output logic [DATA_W-1:0]        rdata,
  output logic                     wrt_enab,
  output logic [ADDR_W-1:0]        wadd,
  output logic [ADDR_W-1:0]        radd,
  output logic [DATA_W-1:0]        d_in,
  input  logic [DATA_W-1:0]        d_out
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  state_t state, nxt;
  logic [PW-1:0] ptr, win_q, sel_idx;
  logic [NREQ-1:0] win_oh;
  logic any_req, op_wr, sel_wr;
  logic [ADDR_W-1:0] addr_q, sel_addr;
  logic [DATA_W-1:0] wdata_q, sel_wdata;
  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req     (req),
    .ptr     (ptr),
    .win     (win_oh),
    .any_req (any_req)
  );
  always_comb begin
    sel_idx = '0;
    sel_wr = 1'b0;
    sel_addr = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++)
      if (win_oh[i]) begin
        sel_idx = PW'(i);
        sel_wr = wr[i];
        sel_addr = addr[i*ADDR_W +: ADDR_W];
        sel_wdata = wdata[i*DATA_W +: DATA_W];
      end
  end
  always_ff @(posedge clk or posedge clr)
    if (clr) state <= ST_IDLE;
    else state <= nxt;
  // Array drive is decoded from state so reset kills a pending write before its negedge.
  always_comb begin
    nxt = (state == ST_IDLE) ? (any_req ? ST_ACCESS : ST_IDLE) :
          (state == ST_ACCESS) ? ST_ACK : ST_IDLE;
    wrt_enab = (state == ST_ACCESS) && op_wr;
    ack = (state == ST_ACK) ? gnt : '0;
    wadd = addr_q;
    radd = addr_q;
    d_in = wdata_q;
  end
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      ptr <= '0;
      win_q <= '0;
      gnt <= '0;
      op_wr <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata <= '0;
    end else begin
      if (state == ST_IDLE && any_req) begin
        win_q <= sel_idx;
        gnt <= win_oh;
        op_wr <= sel_wr;
        addr_q <= sel_addr;
        wdata_q <= sel_wdata;
      end
      if (state == ST_ACCESS) begin
        if (!op_wr) rdata <= d_out;
        ptr <= (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;
      end
      if (state == ST_ACK) gnt <= '0;
    end
endmodule

// File: tb/tb_reg_array_arbiter.sv
// tb_reg_array_arbiter: randomized and directed checks of the arbiter against a transaction model
module tb_reg_array_arbiter;
  localparam int NREQ = 4;
  logic clk = 1'b0, clr = 1'b1, arr_clr_n = 1'b0;
  logic [3:0] req_drv = '0, wr_drv = '0, hold = '0;
  logic [1:0] addr_drv [4];
  logic [3:0] wd_drv [4];
  logic [7:0] addr_p;
  logic [15:0] wdata_p;
  logic [3:0] gnt, ack, rdata, d_in, d_out;
  logic wrt_enab;
  logic [1:0] wadd, radd;
  logic [3:0] arr [4];
  logic [3:0] ref_mem [4];
  int n_chk = 0, n_fail = 0, cyc = 0, free_at = 0, g_at = -100, mptr = 0;
  int m_win = 0, m_addr = 0, m_data = 0, m_exp = 0, exp_rdata = 0, old;
  bit m_wr = 0;
  int since [4];
  int served [4];
  int rd_obs [4];
  int order_q [$];

  always #5 clk = ~clk;

  always_comb
    for (int i = 0; i < 4; i++) begin
      addr_p[i*2 +: 2] = addr_drv[i];
      wdata_p[i*4 +: 4] = wd_drv[i];
    end

  always @(negedge clk or negedge arr_clr_n)
    if (!arr_clr_n) for (int i = 0; i < 4; i++) arr[i] <= '0;
    else if (wrt_enab) arr[wadd] <= d_in;
  assign d_out = arr[radd];

  reg_array_arbiter #(.NREQ(4), .ADDR_W(2), .DATA_W(4)) dut (
    .clk(clk), .clr(clr), .req(req_drv), .wr(wr_drv), .addr(addr_p), .wdata(wdata_p),
    .gnt(gnt), .ack(ack), .rdata(rdata), .wrt_enab(wrt_enab), .wadd(wadd), .radd(radd),
    .d_in(d_in), .d_out(d_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int rr_model(input logic [3:0] r, input int p);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  task automatic post(input int i, input bit w, input int a, input int d);
    req_drv[i] = 1'b1;
    wr_drv[i] = w;
    addr_drv[i] = 2'(a);
    wd_drv[i] = 4'(d);
    since[i] = cyc + 1;
  endtask

  // One clock: model decides grants at posedge, outputs are checked at the following negedge.
  task automatic step();
    bit in_acc, in_ack;
    @(posedge clk);
    cyc++;
    if (cyc >= free_at && req_drv != 0) begin
      m_win = rr_model(req_drv, mptr);
      m_wr = wr_drv[m_win];
      m_addr = addr_drv[m_win];
      m_data = wd_drv[m_win];
      m_exp = ref_mem[m_addr];
      if (m_wr) ref_mem[m_addr] = 4'(m_data);
      mptr = (m_win + 1) % NREQ;
      g_at = cyc;
      free_at = cyc + 3;
      order_q.push_back(m_win);
    end
    @(negedge clk);
    in_acc = (cyc == g_at);
    in_ack = (cyc == g_at + 1);
    if (in_ack && !m_wr) exp_rdata = m_exp;
    check("gnt", gnt, (in_acc || in_ack) ? (32'd1 << m_win) : 32'd0);
    check("ack", ack, in_ack ? (32'd1 << m_win) : 32'd0);
    check("wrt_enab", wrt_enab, in_acc && m_wr);
    check("rdata", rdata, exp_rdata);
    if (in_acc) begin
      check("wadd", wadd, m_addr);
      check("radd", radd, m_addr);
      if (m_wr) check("d_in", d_in, m_data);
    end
    if (in_ack) begin
      check("latency", (g_at + 2 - since[m_win]) <= 3 * NREQ, 1);
      served[m_win]++;
      if (!m_wr) rd_obs[m_win] = rdata;
      if (hold[m_win]) since[m_win] = cyc + 1;
      else req_drv[m_win] = 1'b0;
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((req_drv != 0 || cyc < free_at) && n < budget) begin
      step();
      n++;
    end
    check("drain_timeout", n < budget, 1);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      addr_drv[i] = '0; wd_drv[i] = '0; ref_mem[i] = '0;
      since[i] = 0; served[i] = 0; rd_obs[i] = 0;
    end
    #12;
    check("rst_gnt", gnt, 0);
    check("rst_ack", ack, 0);
    check("rst_rdata", rdata, 0);
    check("rst_wen", wrt_enab, 0);
    check("rst_wadd", wadd, 0);
    check("rst_radd", radd, 0);
    check("rst_d_in", d_in, 0);
    @(negedge clk);
    clr = 1'b0;
    arr_clr_n = 1'b1;
    // all four write at once after reset: order 0..3, then read back
    for (int i = 0; i < 4; i++) post(i, 1, i, i + 1);
    drain(40);
    check("t2_count", order_q.size(), 4);
    for (int i = 0; i < 4; i++) check("t2_order", order_q[i], i);
    for (int i = 0; i < 4; i++) post(i, 0, i, 0);
    drain(40);
    for (int i = 0; i < 4; i++) check("t2_read", rd_obs[i], i + 1);
    // single write then read
    post(0, 1, 2, 4'hA);
    drain(20);
    post(0, 0, 2, 0);
    drain(20);
    check("t1_read", rd_obs[0], 4'hA);
    // two held requesters alternate
    order_q.delete();
    hold = 4'b1010;
    post(1, 0, 1, 0);
    post(3, 0, 3, 0);
    repeat (24) step();
    hold = '0;
    drain(20);
    check("t3_min", order_q.size() >= 6, 1);
    for (int i = 1; i < order_q.size(); i++) check("t3_alt", order_q[i] != order_q[i-1], 1);
    check("t3_fair", (served[1] - served[3] <= 1) && (served[3] - served[1] <= 1), 1);
    // withdraw during ACCESS: op still completes
    post(2, 1, 1, 4'h5);
    step();
    req_drv[2] = 1'b0;
    addr_drv[2] = 2'd0;
    wd_drv[2] = 4'h0;
    drain(20);
    post(2, 0, 1, 0);
    drain(20);
    check("t4_read", rd_obs[2], 4'h5);
    // async reset in the middle of a write
    old = ref_mem[3];
    post(2, 1, 3, 4'hF);
    @(posedge clk);
    cyc++;
    #1 clr = 1'b1;
    #1;
    check("t5_gnt", gnt, 0);
    check("t5_wen", wrt_enab, 0);
    check("t5_ack", ack, 0);
    check("t5_rdata", rdata, 0);
    check("t5_wadd", wadd, 0);
    @(negedge clk);
    check("t5_arr", arr[3], old);
    clr = 1'b0;
    req_drv = '0;
    mptr = 0;
    g_at = -100;
    exp_rdata = 0;
    free_at = cyc + 1;
    order_q.delete();
    post(1, 0, 3, 0);
    post(3, 0, 0, 0);
    drain(30);
    check("t5_count", order_q.size(), 2);
    check("t5_first", order_q[0], 1);
    // idle: nothing moves for 20 cycles
    repeat (20) step();
    for (int i = 0; i < 4; i++) check("t6_arr", arr[i], ref_mem[i]);
    // random traffic with addr/data scrambled while a grant is in flight
    repeat (400) begin
      step();
      if (cyc == g_at && $urandom_range(0, 1) == 1) begin
        addr_drv[m_win] = 2'($urandom);
        wd_drv[m_win] = 4'($urandom);
      end
      for (int i = 0; i < 4; i++)
        if (!req_drv[i] && $urandom_range(0, 2) == 0)
          post(i, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 15));
    end
    drain(60);
    for (int i = 0; i < 4; i++) check("final_arr", arr[i], ref_mem[i]);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
